// File: rtl/led_ctrl_pkg.sv
// LED pattern controller shared constants.
// Mode codes, register map, CTRL fields, FSM states.
package led_ctrl_pkg;

  localparam logic [2:0] MODE_STATIC = 3'd0;
  localparam logic [2:0] MODE_ROTL   = 3'd1;
  localparam logic [2:0] MODE_ROTR   = 3'd2;
  localparam logic [2:0] MODE_BLINK  = 3'd3;
  localparam logic [2:0] MODE_BOUNCE = 3'd4;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_CURRENT = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  function automatic logic [31:0] rotl(
    input logic [31:0] v
  );
    return {v[30:0], v[31]};
  endfunction

  function automatic logic [31:0] rotr(
    input logic [31:0] v
  );
    return {v[0], v[31:1]};
  endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Peripheral bus bundle for the LED controller.
// CPU bridge is master, controller is slave.
interface led_ctrl_if;

  logic        bus_we;
  logic        bus_re;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_we,
    output bus_re,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_we,
    input  bus_re,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/led_ctrl_tick_gen.sv
// Period counter for the LED controller.
// tick is the advance strobe for the current cycle.
module led_tick_gen (
  input  logic        clk_in,
  input  logic        sys_rst,
  input  logic        run,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt;
  logic [31:0] last;

  // a period of 0 counts like a period of 1
  assign last = (period == 32'd0) ? 32'd0 : period - 32'd1;
  assign tick = run && !clear && (cnt >= last);

  // count while running, wrap on the strobe
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (!run || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped 32-LED pattern controller.
// Registers, reload logic and registered pin drive.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PERIOD  = 32'd25_000_000,
  parameter logic [31:0] DEFAULT_PATTERN = 32'h0000_0001
) (
  input  logic        clk_in,
  input  logic        sys_rst,
  led_ctrl_if.slave   bus,
  output logic        tick,
  output logic [31:0] led_light
);

  logic        en_q, en_n;
  logic [2:0]  mode_q, mode_n;
  logic [31:0] period_q, period_n;
  logic [31:0] pattern_q, pattern_n;
  logic [31:0] led_q, led_n;
  logic        dir_q, dir_n;
  logic        phase_q, phase_n;
  logic [0:0]  state_q, state_n;
  logic [31:0] rdata_q, rd_val;
  logic [31:0] light_n;
  logic        wr_ctrl, wr_period, wr_pattern;
  logic        wr, step;

  assign wr_ctrl    = bus.bus_we && (bus.bus_addr == ADDR_CTRL);
  assign wr_period  = bus.bus_we && (bus.bus_addr == ADDR_PERIOD);
  assign wr_pattern = bus.bus_we && (bus.bus_addr == ADDR_PATTERN);
  assign wr         = wr_ctrl || wr_period || wr_pattern;

  assign bus.bus_rdata = rdata_q;

  led_tick_gen u_tick (
    .clk_in (clk_in),
    .sys_rst(sys_rst),
    .run    (state_q == ST_RUN),
    .clear  (wr),
    .period (period_q),
    .tick   (step)
  );

  // next register image: a write reloads, else a strobe advances
  always_comb begin
    en_n      = en_q;
    mode_n    = mode_q;
    period_n  = period_q;
    pattern_n = pattern_q;
    led_n     = led_q;
    dir_n     = dir_q;
    phase_n   = phase_q;
    if (wr_ctrl) begin
      en_n   = bus.bus_wdata[CTRL_EN];
      mode_n = bus.bus_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
    end
    if (wr_period) period_n = bus.bus_wdata;
    if (wr_pattern) pattern_n = bus.bus_wdata;
    if (wr) begin
      led_n   = pattern_n;
      dir_n   = DIR_L;
      phase_n = 1'b0;
    end else if (step) begin
      unique case (1'b1)
        mode_q == MODE_ROTL:  led_n = rotl(led_q);
        mode_q == MODE_ROTR:  led_n = rotr(led_q);
        mode_q == MODE_BLINK: phase_n = ~phase_q;
        mode_q == MODE_BOUNCE: begin
          if (dir_q == DIR_L) begin
            if (led_q[31]) begin
              dir_n = DIR_R;
              led_n = rotr(led_q);
            end else begin
              led_n = rotl(led_q);
            end
          end else begin
            if (led_q[0]) begin
              dir_n = DIR_L;
              led_n = rotl(led_q);
            end else begin
              led_n = rotr(led_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM follows en; pins are built from next-state values
  always_comb begin
    state_n = en_n ? ST_RUN : ST_IDLE;
    light_n = '1;
    if (state_n == ST_RUN) begin
      if (mode_n == MODE_BLINK && phase_n) begin
        light_n = '1;
      end else begin
        light_n = ~led_n;
      end
    end
  end

  // read mux over the pre-write register values
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      bus.bus_addr == ADDR_CTRL:    rd_val = {28'd0, mode_q, en_q};
      bus.bus_addr == ADDR_PERIOD:  rd_val = period_q;
      bus.bus_addr == ADDR_PATTERN: rd_val = pattern_q;
      default:                      rd_val = led_q;
    endcase
  end

  // state, read data and pin registers
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_STATIC;
      period_q  <= DEFAULT_PERIOD;
      pattern_q <= DEFAULT_PATTERN;
      led_q     <= DEFAULT_PATTERN;
      dir_q     <= DIR_L;
      phase_q   <= 1'b0;
      state_q   <= ST_IDLE;
      rdata_q   <= '0;
      tick      <= 1'b0;
      led_light <= '1;
    end else begin
      en_q      <= en_n;
      mode_q    <= mode_n;
      period_q  <= period_n;
      pattern_q <= pattern_n;
      led_q     <= led_n;
      dir_q     <= dir_n;
      phase_q   <= phase_n;
      state_q   <= state_n;
      if (bus.bus_re) rdata_q <= rd_val;
      tick      <= step;
      led_light <= light_n;
    end
  end

endmodule
